// File: rtl/mdl_dmadreg_wordbuf_pkg.sv
// Shared definitions for the DMA data-register word buffer.
//   state_e      : word-buffer FSM encoding
//   WORD_W/BYTE_W: data path widths
//   HOLD_CYC_*   : legal range of the post-ACK hold time, in 2 MHz ticks
//   hold_load()  : counter preload for a given hold time, clamped to the range
package mdl_dmadreg_wordbuf_pkg;

    localparam int WORD_W       = 16;
    localparam int BYTE_W       = 8;
    localparam int HOLD_CYC_MIN = 1;
    localparam int HOLD_CYC_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_END  = 2'd3
    } state_e;

    // The counter is checked for zero before decrementing, so HOLD lasts
    // preload+1 ticks; preload is therefore HOLD_CYC-1.
    function automatic logic [3:0] hold_load(input int cyc);
        if (cyc < HOLD_CYC_MIN) return 4'd0;
        if (cyc > HOLD_CYC_MAX) return 4'd14;
        return 4'(cyc - 1);
    endfunction

endpackage

// File: rtl/mdl_dmadreg_wordbuf_if.sv
// Byte-in / word-out bus of the DMA data-register word buffer.
//   slave  : used by mdl_dmadreg_wordbuf (byte strobes and ACK in, word/REQ out)
//   master : used by the driving side
// Optional macro MDL_DMADREG_WORDBUF_BYTESWAP_EN adds i_SWAP.
interface mdl_dmadreg_wordbuf_if;
    import mdl_dmadreg_wordbuf_pkg::*;

    logic [BYTE_W-1:0] i_BYTE_DATA;
    logic              i_NEWBYTE;
    logic              i_DMADREG_BDHI_LD;
    logic              i_DMADREG_BDLO_LD;
    logic              i_DMA_ACK;
    logic              i_DMA_ABORT;
`ifdef MDL_DMADREG_WORDBUF_BYTESWAP_EN
    logic              i_SWAP;
`endif
    logic              o_DMA_REQ;
    logic [WORD_W-1:0] o_DMA_DATA;
    logic              o_DMA_WORD_END;
    logic              o_BUSY;
    logic              o_OVRN;

    modport slave (
`ifdef MDL_DMADREG_WORDBUF_BYTESWAP_EN
        input  i_SWAP,
`endif
        input  i_BYTE_DATA, i_NEWBYTE, i_DMADREG_BDHI_LD, i_DMADREG_BDLO_LD,
        input  i_DMA_ACK, i_DMA_ABORT,
        output o_DMA_REQ, o_DMA_DATA, o_DMA_WORD_END, o_BUSY, o_OVRN
    );

    modport master (
`ifdef MDL_DMADREG_WORDBUF_BYTESWAP_EN
        output i_SWAP,
`endif
        output i_BYTE_DATA, i_NEWBYTE, i_DMADREG_BDHI_LD, i_DMADREG_BDLO_LD,
        output i_DMA_ACK, i_DMA_ABORT,
        input  o_DMA_REQ, o_DMA_DATA, o_DMA_WORD_END, o_BUSY, o_OVRN
    );

endinterface

// File: rtl/mdl_dmadreg_holdcnt.sv
// 4-bit loadable down-counter advancing only on clock-enable ticks.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   tick_i        : clock enable (one 2 MHz tick)
//   load_i        : load load_val_i (priority over dec_i)
//   load_val_i    : preload value
//   dec_i         : decrement by one, saturating at zero
//   zero_o        : counter is zero
module mdl_dmadreg_holdcnt (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= 4'd0;
        else if (tick_i)
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mdl_dmadreg_wordbuf.sv
// DMA data-register word buffer: assembles HI/LO bytes into a 16-bit word,
// double-buffers it into an output latch and runs REQ/ACK toward the bus,
// returning a one-tick WORD_END to the upstream HI/LO load controller.
//   i_MCLK          : master clock
//   i_SYS_RST       : synchronous reset, active-high
//   i_CLK2M_PCEN_n  : 2 MHz enable, active-low; state moves only when low
//   bus (slave)     : byte strobes, ACK/ABORT in; REQ, DATA, WORD_END, BUSY, OVRN out
// Parameters: HOLD_CYC (1..15) ticks of data hold after ACK;
//             ABORT_END (1 = abort still pulses WORD_END, 0 = silent).
// Optional macro MDL_DMADREG_WORDBUF_BYTESWAP_EN: i_SWAP=1 latches {LO,HI}.
module mdl_dmadreg_wordbuf
    import mdl_dmadreg_wordbuf_pkg::*;
#(
    parameter int HOLD_CYC  = 2,
    parameter int ABORT_END = 1
) (
    input  logic                  i_MCLK,
    input  logic                  i_SYS_RST,
    input  logic                  i_CLK2M_PCEN_n,
    mdl_dmadreg_wordbuf_if.slave  bus
);

    localparam logic [3:0] HOLD_LOAD = hold_load(HOLD_CYC);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] asm_hi_q, asm_hi_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              ovrn_q, ovrn_d;

    logic tick;
    logic lo_ld, hi_ld, can_accept;
    logic cnt_load, cnt_dec, cnt_zero;
    logic [WORD_W-1:0] new_word;

    assign tick  = ~i_CLK2M_PCEN_n;
    assign lo_ld = bus.i_NEWBYTE & bus.i_DMADREG_BDLO_LD;
    // Both strobes high counts as a LO load only.
    assign hi_ld = bus.i_NEWBYTE & bus.i_DMADREG_BDHI_LD & ~bus.i_DMADREG_BDLO_LD;
    // END may accept a new word: its output latch has already been consumed.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_END);

`ifdef MDL_DMADREG_WORDBUF_BYTESWAP_EN
    assign new_word = bus.i_SWAP ? {bus.i_BYTE_DATA, asm_hi_q}
                                 : {asm_hi_q, bus.i_BYTE_DATA};
`else
    assign new_word = {asm_hi_q, bus.i_BYTE_DATA};
`endif

    always_comb begin
        state_d  = state_q;
        asm_hi_d = asm_hi_q;
        data_d   = data_q;
        ovrn_d   = ovrn_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        if (hi_ld)
            asm_hi_d = bus.i_BYTE_DATA;

        if (lo_ld) begin
            if (can_accept)
                data_d = new_word;
            else
                ovrn_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (lo_ld)
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.i_DMA_ABORT)
                    state_d = (ABORT_END != 0) ? ST_END : ST_IDLE;
                else if (bus.i_DMA_ACK) begin
                    cnt_load = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.i_DMA_ABORT)
                    state_d = (ABORT_END != 0) ? ST_END : ST_IDLE;
                else if (cnt_zero)
                    state_d = ST_END;
                else
                    cnt_dec = 1'b1;
            end
            ST_END: begin
                state_d = lo_ld ? ST_REQ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_MCLK) begin
        if (i_SYS_RST) begin
            state_q  <= ST_IDLE;
            asm_hi_q <= '0;
            data_q   <= '0;
            ovrn_q   <= 1'b0;
        end else if (tick) begin
            state_q  <= state_d;
            asm_hi_q <= asm_hi_d;
            data_q   <= data_d;
            ovrn_q   <= ovrn_d;
        end
    end

    mdl_dmadreg_holdcnt u_holdcnt (
        .clk_i      (i_MCLK),
        .rst_i      (i_SYS_RST),
        .tick_i     (tick),
        .load_i     (cnt_load),
        .load_val_i (HOLD_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign bus.o_DMA_REQ      = (state_q == ST_REQ);
    assign bus.o_DMA_DATA     = data_q;
    assign bus.o_DMA_WORD_END = (state_q == ST_END);
    assign bus.o_BUSY         = (state_q != ST_IDLE);
    assign bus.o_OVRN         = ovrn_q;

endmodule

// File: doc/mdl_dmadreg_wordbuf.md
Name: mdl_dmadreg_wordbuf

Overview:
- Downstream neighbour of the DMA data-register HI/LO load controller.
- Captures acquired bubble bytes into a HI/LO assembly register, guided by NEWBYTE and the BDHI_LD/BDLO_LD strobes.
- Double-buffers each completed 16-bit word and runs the DMA request/acknowledge handshake toward the bus side.
- Returns DMA_WORD_END to the load controller so its HI/LO toggle re-arms on HI.

Parameters:
- HOLD_CYC, 2: number of 2 MHz enable ticks the output word is held after ACK, before WORD_END. Legal range 1..15.
- ABORT_END, 1: 1 = an abort still issues one WORD_END pulse to resync upstream; 0 = silent abort.

Ports:
- i_MCLK  in  1  master clock
- i_SYS_RST  in  1  synchronous reset, active-high
- i_CLK2M_PCEN_n  in  1  2 MHz clock enable, active-low; all state advances only when this is low
- i_BYTE_DATA  in  8  acquired byte, valid while i_NEWBYTE is high
- i_NEWBYTE  in  1  byte-valid strobe
- i_DMADREG_BDHI_LD  in  1  next byte goes to the HI half
- i_DMADREG_BDLO_LD  in  1  next byte goes to the LO half
- i_DMA_ACK  in  1  bus grant/ack, level
- i_DMA_ABORT  in  1  cancel the pending transfer
- o_DMA_REQ  out  1  word ready, requesting bus
- o_DMA_DATA  out  16  output latch, {HI,LO}
- o_DMA_WORD_END  out  1  one-tick pulse back to the load controller
- o_BUSY  out  1  FSM not in IDLE
- o_OVRN  out  1  sticky overrun flag

Behaviour:
- Tick: a rising i_MCLK edge with i_CLK2M_PCEN_n low. Nothing changes on other edges.
- Reset (synchronous, any state): all registers 0, FSM = IDLE. Outputs o_DMA_REQ, o_DMA_WORD_END, o_BUSY and o_OVRN are 0; o_DMA_DATA = 16'h0000.
- HI load: on a tick with i_NEWBYTE & i_DMADREG_BDHI_LD, asm_hi <= i_BYTE_DATA.
- LO load: on a tick with i_NEWBYTE & i_DMADREG_BDLO_LD, the word completes.
  - If the FSM is IDLE or END: out latch <= {asm_hi, i_BYTE_DATA}; FSM -> REQ on the next tick.
  - Otherwise: word dropped, o_OVRN <= 1. o_OVRN is cleared only by reset.
- HI and LO strobes both high: treat as LO only.
- FSM states: IDLE, REQ, HOLD, END.
  - IDLE: o_DMA_REQ = 0; waits for a LO load.
  - REQ: o_DMA_REQ = 1. On i_DMA_ACK sampled at a tick: o_DMA_REQ drops, hold counter <= HOLD_CYC-1, go to HOLD. Minimum REQ duration is 1 tick; ACK already high on REQ entry is accepted on the first REQ tick.
  - HOLD: o_DMA_DATA stable. Counter decrements each tick; at 0 go to END.
  - END: o_DMA_WORD_END = 1 for exactly one tick, then IDLE. If a LO load occurs during END, go directly to REQ.
- Latency: LO strobe tick -> o_DMA_REQ high 1 tick later. ACK tick -> o_DMA_WORD_END is HOLD_CYC+1 ticks later.
- i_DMA_ABORT in REQ or HOLD, checked with priority over ACK and the counter:
  - ABORT_END=1: go to END, pulse WORD_END, out latch unchanged.
  - ABORT_END=0: go to IDLE.
- i_DMA_ABORT in IDLE or END: ignored.
- o_DMA_DATA changes only on an accepted LO load; it never changes in HOLD.
- o_BUSY = (state != IDLE).

Optional Feature:
- Macro: MDL_DMADREG_WORDBUF_BYTESWAP_EN.
- Defined: adds input i_SWAP. When i_SWAP = 1 at the LO-load tick, the out latch captures {LO,HI} instead of {HI,LO}.
- Undefined: no i_SWAP port; order is always {HI,LO}.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, HOLD=2'd2, END=2'd3.
  - Word width constant = 16 and byte width constant = 8.
  - HOLD_CYC range limits.
- One natural sub-module, mdl_dmadreg_holdcnt: 4-bit loadable down-counter gated by the clock enable, with a zero flag.

Test Plan:
- HI=8'hA5 then LO=8'h3C, ACK 2 ticks after REQ, HOLD_CYC=2 -> o_DMA_DATA=16'hA53C; REQ high for 2 ticks; WORD_END a single-tick pulse 3 ticks after the ACK tick.
- Second LO load (HI=8'h11, LO=8'h22) while in HOLD -> o_OVRN=1 and stays set; o_DMA_DATA still 16'hA53C; no second REQ.
- LO load coincident with the END tick -> WORD_END pulses once, FSM goes directly to REQ, o_DMA_DATA updates to the new word.
- Abort in REQ:
  - ABORT_END=1 -> REQ drops, one WORD_END pulse, IDLE.
  - ABORT_END=0 -> IDLE with no pulse.
- i_SYS_RST high during HOLD -> next tick: all outputs 0, o_DMA_DATA=16'h0000, state IDLE.
- i_CLK2M_PCEN_n held high for 10 MCLK with strobes and ACK active -> no state or output change.
- Byte-swap macro defined, i_SWAP=1 with HI=8'hA5, LO=8'h3C -> o_DMA_DATA=16'h3CA5.
